// File: rtl/flash_pkg.sv
// Shared types and constants for the SPI flash single-byte read engine.
package flash_pkg;

  localparam int FLASH_ADDR_W = 24;
  localparam int SAMPLE_W     = 8;
  localparam int XFER_BITS    = 40;
  localparam logic [7:0] READ_OPCODE_DEFAULT = 8'h03;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flash_read_controller_spi_clk_gen.sv
// SPI mode-0 clock divider: sclk toggles every CLK_DIV clk cycles while enabled,
// with single-cycle ticks in the cycle before each rising/falling sclk edge.
module spi_clk_gen
  import flash_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam int CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_wrap;

  assign w_wrap = i_en && (r_cnt == LAST);

  // Dropping enable restarts the divider so every transfer begins with a full half-period.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_sclk      = r_sclk;
  assign o_rise_tick = w_wrap && !r_sclk;
  assign o_fall_tick = w_wrap && r_sclk;

endmodule

// File: rtl/flash_read_controller.sv
// Single-byte SPI flash READ engine: takes a 24-bit address over valid/ready,
// clocks out opcode+address, shifts in one data byte, and pulses rsp_valid.
module flash_read_controller
  import flash_pkg::*;
#(
  parameter int         CLK_DIV     = 4,
  parameter logic [7:0] READ_OPCODE = READ_OPCODE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [FLASH_ADDR_W-1:0] req_addr,
  output logic                    rsp_valid,
  output logic [SAMPLE_W-1:0]     rsp_data,
  output logic                    spi_cs_n,
  output logic                    spi_sclk,
  output logic                    spi_mosi,
  input  logic                    spi_miso,
  output state_t                  o_dbg_state
);

  localparam int SHIFT_W = 8 + FLASH_ADDR_W;
  localparam int RW      = cnt_width(2 * CLK_DIV);
  localparam logic [RW-1:0] REC_LAST = RW'(2 * CLK_DIV - 1);
  localparam logic [5:0]    BIT_LAST = 6'(XFER_BITS - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_req_ready;
  logic                r_cs_n;
  logic [SHIFT_W-1:0]  r_shift;
  logic [SAMPLE_W-1:0] r_rx;
  logic                r_rsp_valid;
  logic [SAMPLE_W-1:0] r_rsp_data;
  logic [5:0]          r_bit_cnt;
  logic [RW-1:0]       r_rec_cnt;
  logic                w_hs;
  logic                w_sclk;
  logic                w_rise;
  logic                w_fall;
  logic                w_last_fall;

  // Request handshake: a transfer happens on any cycle with req_valid && req_ready;
  // req_addr is captured only then, and req_ready stays low until CS recovery ends.
  assign w_hs        = req_valid && r_req_ready;
  assign w_last_fall = w_fall && (r_bit_cnt == BIT_LAST);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_en        (r_state == SHIFT),
    .o_sclk      (w_sclk),
    .o_rise_tick (w_rise),
    .o_fall_tick (w_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next_state = SHIFT;
      SHIFT:   if (w_last_fall) w_next_state = RECOVER;
      RECOVER: if (r_rec_cnt == REC_LAST) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Ready and CS are registered from the next state so both are glitch-free flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_ready <= 1'b0;
      r_cs_n      <= 1'b1;
      r_shift     <= '0;
      r_rx        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_bit_cnt   <= '0;
      r_rec_cnt   <= '0;
    end else begin
      r_req_ready <= (w_next_state == IDLE);
      r_cs_n      <= (w_next_state != SHIFT);
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_bit_cnt <= '0;
          r_rec_cnt <= '0;
          if (w_hs) r_shift <= {READ_OPCODE, req_addr};
        end
        SHIFT: begin
          if (w_rise) r_rx <= {r_rx[SAMPLE_W-2:0], spi_miso};
          // Zero fill means MOSI is already low by the time the data byte is clocked.
          if (w_fall) begin
            r_shift   <= {r_shift[SHIFT_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 6'd1;
          end
          if (w_last_fall) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_rx;
          end
        end
        RECOVER: r_rec_cnt <= r_rec_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign spi_cs_n    = r_cs_n;
  assign spi_sclk    = w_sclk;
  assign spi_mosi    = r_shift[SHIFT_W-1];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_flash_read_controller.sv
// Directed bench: two controllers (CLK_DIV=4 and CLK_DIV=1) each attached to a
// behavioural SPI flash that records the command stream and returns a set byte.
module tb_flash_read_controller;
  import flash_pkg::*;

  logic        clk;
  logic        reset;
  logic [23:0] req_addr;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data [2];
  logic [1:0]  cs_n;
  logic [1:0]  sclk;
  logic [1:0]  mosi;
  logic [1:0]  miso;
  state_t      dbg_state [2];

  logic [39:0] cap [2];
  logic [7:0]  fdata [2];
  int          rises [2];
  int          falls [2];
  int          tog [2];
  int          rsp_cnt [2];
  logic        pcs [2];
  logic        psclk [2];

  int checks;
  int errors;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  flash_read_controller #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]),
    .o_dbg_state(dbg_state[0])
  );

  flash_read_controller #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]),
    .o_dbg_state(dbg_state[1])
  );

  // flash models: capture MOSI on SCLK rise, drive data byte after falls 32..39
  for (genvar g = 0; g < 2; g++) begin : g_flash
    initial begin
      miso[g] = 1'b0; cap[g] = '0; rises[g] = 0; falls[g] = 0; tog[g] = 0; rsp_cnt[g] = 0;
      pcs[g] = 1'b1; psclk[g] = 1'b0; fdata[g] = 8'h00;
    end
    always @(cs_n[g], sclk[g]) begin
      if (cs_n[g] === 1'b0 && pcs[g] !== 1'b0) begin
        cap[g] = '0; rises[g] = 0; falls[g] = 0;
      end else if (cs_n[g] === 1'b0) begin
        if (sclk[g] === 1'b1 && psclk[g] !== 1'b1) begin
          cap[g] = {cap[g][38:0], mosi[g]};
          rises[g]++;
        end else if (sclk[g] === 1'b0 && psclk[g] === 1'b1) begin
          falls[g]++;
          if (falls[g] >= 32 && falls[g] < 40) miso[g] = fdata[g][39 - falls[g]];
        end
      end
      pcs[g] = cs_n[g];
      psclk[g] = sclk[g];
    end
    always @(sclk[g]) tog[g]++;
    always @(negedge clk) if (rsp_valid[g] === 1'b1) rsp_cnt[g]++;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int t0 [2];
    reset = 1'b1; req_valid = '0; req_addr = '0;
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (req_ready[g] !== 1'b0) begin
        errors++; $display("FAIL reset_ready_low[%0d]: got %b expected 0", g, req_ready[g]);
      end
    end
    reset = 1'b0;
    tick();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({req_ready[g], cs_n[g], sclk[g], mosi[g], rsp_valid[g]} !== 5'b11000) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got rdy/cs/sclk/mosi/rv=%b expected 11000", g,
                 {req_ready[g], cs_n[g], sclk[g], mosi[g], rsp_valid[g]});
      end
      checks++;
      if (rsp_data[g] !== 8'h00 || dbg_state[g] !== IDLE) begin
        errors++;
        $display("FAIL reset_data_state[%0d]: got data=%h state=%0d expected 00/IDLE", g,
                 rsp_data[g], dbg_state[g]);
      end
      t0[g] = tog[g];
    end
    repeat (100) tick();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (tog[g] != t0[g] || req_ready[g] !== 1'b1 || cs_n[g] !== 1'b1) begin
        errors++;
        $display("FAIL idle_quiet[%0d]: got toggles=%0d rdy=%b cs=%b expected 0/1/1", g,
                 tog[g] - t0[g], req_ready[g], cs_n[g]);
      end
    end
  endtask

  // driver: one read on instance g, checking latency, stream, data and ready return
  task automatic do_read(input int g, input logic [23:0] addr, input logic [7:0] d,
                         input int lat, input int rdy, input bit change_addr, input string name);
    int cyc;
    logic [39:0] exp_cmd;
    exp_cmd = {8'h03, addr, 8'h00};
    fdata[g] = d; req_addr = addr; req_valid[g] = 1'b1;
    tick();
    cyc = 1;
    req_valid[g] = 1'b0;
    checks++;
    if ({cs_n[g], sclk[g], mosi[g], req_ready[g]} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_t1: got cs/sclk/mosi/rdy=%b expected 0000", name,
               {cs_n[g], sclk[g], mosi[g], req_ready[g]});
    end
    while (rsp_valid[g] !== 1'b1 && cyc < 2000) begin
      tick(); cyc++;
      if (change_addr && cyc == 5) req_addr = 24'hFFFFFF;
    end
    checks++;
    if (cyc != lat) begin
      errors++; $display("FAIL %s_latency: got T0+%0d expected T0+%0d", name, cyc, lat);
    end
    checks++;
    if (rsp_data[g] !== d) begin
      errors++; $display("FAIL %s_data: got %h expected %h", name, rsp_data[g], d);
    end
    checks++;
    if (cap[g] !== exp_cmd || rises[g] != 40) begin
      errors++;
      $display("FAIL %s_stream: got cmd=%h rises=%0d expected cmd=%h rises=40", name,
               cap[g], rises[g], exp_cmd);
    end
    checks++;
    if (cs_n[g] !== 1'b1 || sclk[g] !== 1'b0) begin
      errors++; $display("FAIL %s_end_bus: got cs=%b sclk=%b expected 1/0", name, cs_n[g], sclk[g]);
    end
    tick(); cyc++;
    checks++;
    if (rsp_valid[g] !== 1'b0 || rsp_data[g] !== d) begin
      errors++;
      $display("FAIL %s_pulse: got rv=%b data=%h expected 0/%h", name, rsp_valid[g], rsp_data[g], d);
    end
    while (req_ready[g] !== 1'b1 && cyc < 2000) begin
      tick(); cyc++;
    end
    checks++;
    if (cyc != rdy || cs_n[g] !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got T0+%0d cs=%b expected T0+%0d cs=1", name, cyc, cs_n[g], rdy);
    end
    req_addr = '0;
  endtask

  task automatic test_single_read();
    do_read(0, 24'h012345, 8'hA5, 321, 329, 1'b0, "single");
  endtask

  task automatic test_addr_latch();
    do_read(0, 24'h345678, 8'h0F, 321, 329, 1'b1, "addr_latch");
  endtask

  task automatic test_back_to_back();
    int cyc, n;
    int r_cyc [2];
    logic [7:0] r_data [2];
    logic [39:0] r_cap [2];
    logic hs_ready, cs_330;
    cyc = 0; n = 0; hs_ready = 1'b0; cs_330 = 1'b1;
    r_cyc[0] = 0; r_cyc[1] = 0; r_data[0] = '0; r_data[1] = '0; r_cap[0] = '0; r_cap[1] = '0;
    fdata[0] = 8'h3C; req_addr = 24'h1FFFFF; req_valid[0] = 1'b1;
    while (n < 2 && cyc < 2000) begin
      tick(); cyc++;
      if (cyc == 2) req_addr = 24'h000000;
      if (rsp_valid[0] === 1'b1) begin
        r_cyc[n] = cyc; r_data[n] = rsp_data[0]; r_cap[n] = cap[0]; n++;
        fdata[0] = 8'hC3;
      end
      if (cyc == 329) hs_ready = req_ready[0];
      if (cyc == 330) begin
        cs_330 = cs_n[0];
        req_valid[0] = 1'b0;
      end
    end
    checks++;
    if (n != 2 || r_cyc[0] != 321 || r_cyc[1] != 650) begin
      errors++;
      $display("FAIL b2b_timing: got n=%0d at %0d,%0d expected 2 at 321,650", n, r_cyc[0], r_cyc[1]);
    end
    checks++;
    if (hs_ready !== 1'b1 || cs_330 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_handshake: got rdy@329=%b cs@330=%b expected 1/0", hs_ready, cs_330);
    end
    checks++;
    if (r_data[0] !== 8'h3C || r_data[1] !== 8'hC3) begin
      errors++; $display("FAIL b2b_data: got %h,%h expected 3c,c3", r_data[0], r_data[1]);
    end
    checks++;
    if (r_cap[0] !== 40'h031FFFFF00 || r_cap[1] !== 40'h0300000000) begin
      errors++;
      $display("FAIL b2b_stream: got %h,%h expected 031fffff00,0300000000", r_cap[0], r_cap[1]);
    end
    while (req_ready[0] !== 1'b1 && cyc < 3000) begin
      tick(); cyc++;
    end
    checks++;
    if (req_ready[0] !== 1'b1 || cyc != 658) begin
      errors++; $display("FAIL b2b_final_ready: got T0+%0d expected T0+658", cyc);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, rc;
    fdata[0] = 8'h77; req_addr = 24'h0ABCDE; req_valid[0] = 1'b1;
    tick(); cyc = 1;
    req_valid[0] = 1'b0;
    while (cyc < 100) begin
      tick(); cyc++;
    end
    rc = rsp_cnt[0];
    reset = 1'b1;
    tick();
    checks++;
    if ({cs_n[0], sclk[0], rsp_valid[0], req_ready[0]} !== 4'b1000 || dbg_state[0] !== IDLE) begin
      errors++;
      $display("FAIL abort_bus: got cs/sclk/rv/rdy=%b state=%0d expected 1000/IDLE",
               {cs_n[0], sclk[0], rsp_valid[0], req_ready[0]}, dbg_state[0]);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL abort_ready: got %b expected 1", req_ready[0]);
    end
    repeat (400) tick();
    checks++;
    if (rsp_cnt[0] != rc) begin
      errors++; $display("FAIL abort_no_rsp: got %0d responses expected 0", rsp_cnt[0] - rc);
    end
    do_read(0, 24'h00F00F, 8'h96, 321, 329, 1'b0, "after_abort");
  endtask

  task automatic test_clk_div1();
    int t0;
    t0 = tog[1];
    do_read(1, 24'h00ABCD, 8'h5A, 81, 83, 1'b0, "div1");
    checks++;
    if (tog[1] - t0 != 80) begin
      errors++; $display("FAIL div1_toggles: got %0d expected 80", tog[1] - t0);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; req_valid = '0; req_addr = '0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_addr_latch();
    test_back_to_back();
    test_reset_mid();
    test_clk_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
